proc_ctrl: RTL and testbench

PROC_CTRL -- requirements
Module: proc_ctrl

---
 rtl/proc_ctrl_pkg.sv | 32 +++
 rtl/proc_ctrl_dec3to8.sv | 17 +
 rtl/proc_ctrl.sv | 127 ++++++++++++
 tb/tb_proc_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control FSM: opcodes, state encoding,
// and instruction field layout.
package proc_ctrl_pkg;

  localparam int INSTR_W   = 9;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef struct packed {
    logic [2:0]           op;
    logic [REG_IDX_W-1:0] x;
    logic [REG_IDX_W-1:0] y;
  } instr_t;

  // Opcodes that need the three-step operand/ALU/writeback sequence.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_ctrl_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all-zero when disabled.
module dec3to8
  import proc_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] sel,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/proc_ctrl.sv
// Control FSM of a small multi-cycle processor: captures an instruction on run
// and sequences bus-source selects and register/ALU enables over T1..T3.
module proc_ctrl
  import proc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                run,
  input  logic [INSTR_W-1:0]  instr,
  output logic [NUM_REGS-1:0] Rout_sel,
  output logic                din_sel,
  output logic                ALUout_sel,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Ain,
  output logic                Gin,
  output logic                addsub,
  output logic                done,
  output logic                busy
);

  state_t              state;
  state_t              state_nxt;
  instr_t              ir;
  logic [NUM_REGS-1:0] x_onehot;
  logic [NUM_REGS-1:0] y_onehot;
  logic                dec_en;
  logic                rout_x;
  logic                rout_y;
  logic                rin_x;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
    end else begin
      state <= state_nxt;
    end
  end

  // IR is only writable while idle, so run during an instruction cannot disturb it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir <= '0;
    end else if ((state == T0) && run) begin
      ir <= instr;
    end
  end

  assign dec_en = (state != T0);

  dec3to8 u_dec_x (
    .sel    (ir.x),
    .en     (dec_en),
    .onehot (x_onehot)
  );

  dec3to8 u_dec_y (
    .sel    (ir.y),
    .en     (dec_en),
    .onehot (y_onehot)
  );

  // Next state and control decode; outputs depend on state and IR only.
  always_comb begin
    state_nxt  = state;
    rout_x     = 1'b0;
    rout_y     = 1'b0;
    rin_x      = 1'b0;
    din_sel    = 1'b0;
    ALUout_sel = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    addsub     = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;

    case (state)
      T0: begin
        busy = 1'b0;
        if (run) begin
          state_nxt = T1;
        end
      end

      T1: begin
        if (is_alu_op(ir.op)) begin
          rout_x    = 1'b1;
          Ain       = 1'b1;
          state_nxt = T2;
        end else begin
          done      = 1'b1;
          state_nxt = T0;
          if (ir.op == OP_MV) begin
            rout_y = 1'b1;
            rin_x  = 1'b1;
          end else if (ir.op == OP_MVI) begin
            din_sel = 1'b1;
            rin_x   = 1'b1;
          end
        end
      end

      T2: begin
        rout_y    = 1'b1;
        Gin       = 1'b1;
        addsub    = (ir.op == OP_SUB);
        state_nxt = T3;
      end

      T3: begin
        ALUout_sel = 1'b1;
        rin_x      = 1'b1;
        done       = 1'b1;
        state_nxt  = T0;
      end

      default: begin
        busy      = 1'b0;
        state_nxt = T0;
      end
    endcase
  end

  // Only one of rout_x/rout_y is ever set in a given state, keeping the bus one-hot.
  assign Rout_sel = (rout_x ? x_onehot : '0) | (rout_y ? y_onehot : '0);
  assign Rin      = rin_x ? x_onehot : '0;

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed instruction table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [8:0]  instr;
  logic [7:0]  Rout_sel;
  logic        din_sel;
  logic        ALUout_sel;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        addsub;
  logic        done;
  logic        busy;
  logic [22:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [8:0]  instr;
    int          n;
    logic [22:0] e1;
    logic [22:0] e2;
    logic [22:0] e3;
  } vec_t;

  vec_t        tbl[7];
  logic [22:0] exp_q[$];

  proc_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .instr      (instr),
    .Rout_sel   (Rout_sel),
    .din_sel    (din_sel),
    .ALUout_sel (ALUout_sel),
    .Rin        (Rin),
    .Ain        (Ain),
    .Gin        (Gin),
    .addsub     (addsub),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign outs = {Rout_sel, din_sel, ALUout_sel, Rin, Ain, Gin, addsub, done, busy};

  function automatic logic [22:0] mk(input logic [7:0] rout, input logic din,
                                     input logic alu, input logic [7:0] rin,
                                     input logic ain, input logic gin,
                                     input logic as_, input logic dn);
    return {rout, din, alu, rin, ain, gin, as_, dn, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic chk_bus_onehot();
    int cnt;
    cnt = $countones({Rout_sel, din_sel, ALUout_sel});
    n_tests++;
    if (cnt > 1) begin
      n_fail++;
      $display("FAIL bus_onehot: got %0d sources, expected at most 1", cnt);
    end
  endtask

  // Reference behaviour: expected output vector for each busy cycle of an instruction.
  task automatic push_seq(input logic [8:0] ins);
    logic [2:0] op;
    logic [7:0] xo;
    logic [7:0] yo;
    op = ins[8:6];
    xo = 8'd1 << ins[5:3];
    yo = 8'd1 << ins[2:0];
    if (op == 3'd0) begin
      exp_q.push_back(mk(yo, 0, 0, xo, 0, 0, 0, 1));
    end else if (op == 3'd1) begin
      exp_q.push_back(mk(8'h00, 1, 0, xo, 0, 0, 0, 1));
    end else if (op == 3'd2 || op == 3'd3) begin
      exp_q.push_back(mk(xo, 0, 0, 8'h00, 1, 0, 0, 0));
      exp_q.push_back(mk(yo, 0, 0, 8'h00, 0, 1, (op == 3'd3), 0));
      exp_q.push_back(mk(8'h00, 0, 1, xo, 0, 0, 0, 1));
    end else begin
      exp_q.push_back(mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after T0 is re-checked.
  task automatic run_instr(input vec_t v, input string nm);
    run   = 1'b1;
    instr = v.instr;
    @(negedge clk);
    chk({nm, "_t1"}, outs, v.e1);
    run = 1'b0;
    if (v.n == 3) begin
      @(negedge clk);
      chk({nm, "_t2"}, outs, v.e2);
      @(negedge clk);
      chk({nm, "_t3"}, outs, v.e3);
    end
    @(negedge clk);
    chk({nm, "_t0"}, outs, 23'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{9'b001_010_000, 1, mk(8'h00, 1, 0, 8'h04, 0, 0, 0, 1), 23'd0, 23'd0};
    tbl[1] = '{9'b000_101_001, 1, mk(8'h02, 0, 0, 8'h20, 0, 0, 0, 1), 23'd0, 23'd0};
    tbl[2] = '{9'b011_000_111, 3, mk(8'h01, 0, 0, 8'h00, 1, 0, 0, 0),
               mk(8'h80, 0, 0, 8'h00, 0, 1, 1, 0), mk(8'h00, 0, 1, 8'h01, 0, 0, 0, 1)};
    tbl[3] = '{9'b010_001_010, 3, mk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0),
               mk(8'h04, 0, 0, 8'h00, 0, 1, 0, 0), mk(8'h00, 0, 1, 8'h02, 0, 0, 0, 1)};
    tbl[4] = '{9'b000_011_011, 1, mk(8'h08, 0, 0, 8'h08, 0, 0, 0, 1), 23'd0, 23'd0};
    tbl[5] = '{9'b111_101_110, 1, mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1), 23'd0, 23'd0};
    tbl[6] = '{9'b100_000_000, 1, mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1), 23'd0, 23'd0};

    // Reset held with run asserted: nothing may start.
    resetn = 1'b0;
    run    = 1'b1;
    instr  = 9'b010_001_010;
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", outs, 23'd0);
    run = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", outs, 23'd0);

    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i], $sformatf("tbl%0d", i));
    end

    // run held high; instr changes mid-instruction and must not alter the add.
    run   = 1'b1;
    instr = tbl[3].instr;
    @(negedge clk);
    chk("b2b_t1", outs, tbl[3].e1);
    @(negedge clk);
    chk("b2b_t2", outs, tbl[3].e2);
    instr = tbl[1].instr;
    @(negedge clk);
    chk("b2b_t3", outs, tbl[3].e3);
    @(negedge clk);
    chk("b2b_gap_t0", outs, 23'd0);
    @(negedge clk);
    chk("b2b_next_t1", outs, tbl[1].e1);
    run = 1'b0;
    @(negedge clk);
    chk("b2b_end_t0", outs, 23'd0);

    // Asynchronous reset in T2 of an add.
    run   = 1'b1;
    instr = tbl[3].instr;
    @(negedge clk);
    run = 1'b0;
    chk("rst_mid_t1", outs, tbl[3].e1);
    @(negedge clk);
    chk("rst_mid_t2", outs, tbl[3].e2);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async", outs, 23'd0);
    @(negedge clk);
    chk("rst_held", outs, 23'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_no_resume", outs, 23'd0);
    run_instr(tbl[0], "rst_first_run");

    // Randomized traffic against the queue-based model.
    for (int c = 0; c < 600; c++) begin
      chk("rand", outs, (exp_q.size() != 0) ? exp_q[0] : 23'd0);
      chk_bus_onehot();
      run   = ($urandom_range(0, 3) != 0);
      instr = 9'($urandom);
      if (exp_q.size() == 0) begin
        if (run) push_seq(instr);
      end else begin
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
